mpmc9_app_rd_data_capture: RTL and testbench
============================================

Name: mpmc9_app_rd_data_capture

Overview:
- Read-direction counterpart of the MIG write-data path in mpmc9.
- Collects app_rd_data beats from the MIG user interface (app_rd_data_valid / app_rd_data_end) into full cache lines.
- Pairs each completed line with the channel tag of the oldest outstanding read command.
- Presents completed lines to the channel return logic over a valid/ready handshake. MIG read data has no backpressure, so this block absorbs it and flags loss.

Parameters:
- DW, 128, MIG app data width per beat.
- NBEATS, 2, beats per line (power of two, >=2).
- TAGW, 4, channel tag width.
- TAG_DEPTH, 16, outstanding read tag FIFO entries (power of two).

Ports:
- clk  input  1  controller clock (MIG ui_clk domain).
- rst  input  1  synchronous active-high reset.
- req_push  input  1  read command accepted by MIG this cycle; push req_tag.
- req_tag  input  TAGW  channel tag of accepted read.
- req_full  output  1  tag FIFO full; issuer must not issue reads.
- app_rd_data  input  DW  MIG read data beat.
- app_rd_data_valid  input  1  beat valid.
- app_rd_data_end  input  1  last beat of MIG burst.
- line_valid  output  1  completed line available.
- line_ready  input  1  consumer accepts line.
- line_tag  output  TAGW  tag of presented line.
- line_data  output  DW*NBEATS  line; beat k at bits [k*DW +: DW].
- overflow  output  1  sticky: line or tag dropped.
- beat_err  output  1  sticky: protocol violation.

Behaviour:
- Reset (synchronous, active-high):
  - line_valid=0, req_full=0, overflow=0, beat_err=0, line_tag=0, line_data=0.
  - Beat counter = 0, state = IDLE, both FIFOs empty.
  - Reset mid-line discards the partial line and all outstanding tags.
- Tag FIFO:
  - TAG_DEPTH entries, registered pointers with an extra wrap bit.
  - req_full = (count == TAG_DEPTH), registered.
  - A push while full with no pop in the same cycle is dropped and sets overflow.
  - Simultaneous push and pop when full is accepted.
- States:
  - IDLE, beat counter = 0: a valid beat is stored at beat 0 and moves the block to FILL (or completes the line if NBEATS would be reached; not possible for NBEATS>=2).
  - FILL: each valid beat is stored at the counter index and the counter increments. When the beat stored has counter == NBEATS-1, the line completes, the counter wraps to 0 and the state returns to IDLE.
- app_rd_data_end:
  - Must coincide with the beat at counter NBEATS-1 (or with every beat if the MIG runs 1 beat/burst and NBEATS=1 is not allowed).
  - On a mismatch (end before last beat, or last beat without end when the burst spans the line): set beat_err, discard the partial line, force the counter to 0 and IDLE, and pop one tag.
- Line completion:
  - Pop the tag FIFO head as the line tag.
  - If the tag FIFO is empty at completion: set beat_err, drop the line.
  - Push {tag, line} into a 2-entry output FIFO.
  - Push is accepted if not full, or if a pop occurs in the same cycle. Otherwise the line is dropped, overflow is set, and the tag is still popped.
- Output:
  - line_valid = output FIFO not empty, registered.
  - Latency: line_valid is high the cycle after the clock edge that captured the final beat.
  - line_tag and line_data are held stable while line_valid && !line_ready.
  - Pop on line_valid && line_ready.
- Sticky flags: overflow and beat_err clear only on rst.
- app_rd_data_valid is sampled every cycle regardless of line_ready; no beat is ever stalled.

Optional Feature:
- MPMC9_RDCAP_STATS_EN defined:
  - Adds output port lines_done [31:0]: count of lines accepted by the consumer (line_valid && line_ready). Wraps at 2^32, reset to 0.
  - Adds output port lines_dropped [15:0]: count of lines dropped by overflow or beat_err. Saturates at 16'hFFFF, reset to 0.
- Undefined: neither port exists, no counter logic is present, and all other behaviour is identical.

Test Plan:
- Basic line: reset; req_push tag=3; two beats A0=128'h1, A1=128'h2, with end on the second -> next cycle line_valid=1, line_tag=3, line_data={128'h2,128'h1}. line_ready=1 pops it and line_valid drops the next cycle.
- Ordering: push tags 5,9,2; deliver three lines back-to-back with line_ready=1 -> line_tag sequence 5,9,2 with matching data. overflow=0, beat_err=0.
- Backpressure/overflow: line_ready=0; push 3 tags; deliver 3 lines -> first two held stable, third dropped, overflow=1. Then raise line_ready -> lines 1 and 2 delivered, line_valid=0 after.
- Protocol errors: app_rd_data_end asserted on beat 0 -> beat_err=1, no line output, counter restarts (next good line delivered correctly). A line with no pushed tag -> beat_err=1, no line_valid.
- Tag FIFO full: push 16 tags -> req_full=1. A 17th push -> overflow=1. Complete one line while pushing -> push accepted, req_full stays 1.
- Reset mid-line: one beat delivered, then rst for 1 cycle -> all outputs 0, FIFOs empty. The next full line with a new tag is delivered correctly. With MPMC9_RDCAP_STATS_EN defined, lines_done counts only post-reset accepted lines.

Source files
------------

// File: rtl/mpmc9_app_rd_data_capture_if.sv
// Bus bundle for the MIG read-data capture block: read-tag push, MIG beats, line return and status.
interface mpmc9_app_rd_data_capture_if #(
  parameter int DW     = 128,
  parameter int NBEATS = 2,
  parameter int TAGW   = 4
);
  logic                   req_push;
  logic [TAGW-1:0]        req_tag;
  logic                   req_full;
  logic [DW-1:0]          app_rd_data;
  logic                   app_rd_data_valid;
  logic                   app_rd_data_end;
  logic                   line_valid;
  logic                   line_ready;
  logic [TAGW-1:0]        line_tag;
  logic [DW*NBEATS-1:0]   line_data;
  logic                   overflow;
  logic                   beat_err;

  modport slave (
    input  req_push, req_tag, app_rd_data, app_rd_data_valid, app_rd_data_end, line_ready,
    output req_full, line_valid, line_tag, line_data, overflow, beat_err
  );

  modport master (
    output req_push, req_tag, app_rd_data, app_rd_data_valid, app_rd_data_end, line_ready,
    input  req_full, line_valid, line_tag, line_data, overflow, beat_err
  );
endinterface

// File: rtl/mpmc9_app_rd_data_capture.sv
// Assembles MIG read beats into tagged cache lines with a 2-entry return FIFO.
// Optional MPMC9_RDCAP_STATS_EN adds lines_done / lines_dropped counters.
module mpmc9_app_rd_data_capture #(
  parameter int DW        = 128,
  parameter int NBEATS    = 2,
  parameter int TAGW      = 4,
  parameter int TAG_DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  mpmc9_app_rd_data_capture_if.slave bus
`ifdef MPMC9_RDCAP_STATS_EN
  ,
  output logic [31:0] lines_done,
  output logic [15:0] lines_dropped
`endif
);
  localparam int CW  = $clog2(NBEATS);
  localparam int TPW = $clog2(TAG_DEPTH);
  localparam int LW  = DW * NBEATS;

  typedef enum logic {IDLE, FILL} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   wr_idx;
  logic            line_done, end_err;
  logic [LW-1:0]   line_asm;

  // In IDLE the counter is always zero, so the beat lands at index 0
  assign wr_idx = (state_q == IDLE) ? '0 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    line_done = 1'b0;
    end_err   = 1'b0;
    if (bus.app_rd_data_valid) begin
      if (wr_idx == CW'(NBEATS - 1)) begin
        line_done = bus.app_rd_data_end;
        end_err   = !bus.app_rd_data_end;
        cnt_d     = '0;
        state_d   = IDLE;
      end else if (bus.app_rd_data_end) begin
        end_err = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        cnt_d   = wr_idx + CW'(1);
        state_d = FILL;
      end
    end
  end

  // The final beat bypasses storage and goes straight into the line
  for (genvar gi = 0; gi < NBEATS; gi++) begin : g_beat
    if (gi == NBEATS - 1) begin : g_last
      assign line_asm[gi*DW +: DW] = bus.app_rd_data;
    end else begin : g_store
      logic [DW-1:0] beat_q;
      always_ff @(posedge clk) begin
        if (bus.app_rd_data_valid && wr_idx == CW'(gi))
          beat_q <= bus.app_rd_data;
      end
      assign line_asm[gi*DW +: DW] = beat_q;
    end
  end

  logic [TAGW-1:0] tag_mem [TAG_DEPTH];
  logic [TPW:0]    twr_q, trd_q, twr_d, trd_d;
  logic            req_full_q;
  logic            tag_empty, tag_pop, tag_push_ok, tag_push_drop;
  logic [TAGW-1:0] tag_head;

  assign tag_empty     = (twr_q == trd_q);
  assign tag_pop       = (line_done || end_err) && !tag_empty;
  assign tag_push_ok   = bus.req_push && (!req_full_q || tag_pop);
  assign tag_push_drop = bus.req_push && req_full_q && !tag_pop;
  assign tag_head      = tag_mem[trd_q[TPW-1:0]];
  assign twr_d         = twr_q + {{TPW{1'b0}}, tag_push_ok};
  assign trd_d         = trd_q + {{TPW{1'b0}}, tag_pop};

  always_ff @(posedge clk) begin
    if (tag_push_ok)
      tag_mem[twr_q[TPW-1:0]] <= bus.req_tag;
  end

  logic            line_kept, tag_miss;
  logic [TAGW-1:0] otag_q  [2];
  logic [LW-1:0]   odata_q [2];
  logic [1:0]      owr_q, ord_q, owr_d, ord_d;
  logic            o_full, o_pop, o_push, o_drop;
  logic            line_valid_q, overflow_q, beat_err_q;

  assign line_kept = line_done && !tag_empty;
  assign tag_miss  = line_done && tag_empty;
  assign o_full    = (owr_q[1] != ord_q[1]) && (owr_q[0] == ord_q[0]);
  assign o_pop     = line_valid_q && bus.line_ready;
  assign o_push    = line_kept && (!o_full || o_pop);
  assign o_drop    = line_kept && o_full && !o_pop;
  assign owr_d     = owr_q + {1'b0, o_push};
  assign ord_d     = ord_q + {1'b0, o_pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      twr_q        <= '0;
      trd_q        <= '0;
      req_full_q   <= 1'b0;
      owr_q        <= '0;
      ord_q        <= '0;
      line_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      beat_err_q   <= 1'b0;
      otag_q[0]    <= '0;
      otag_q[1]    <= '0;
      odata_q[0]   <= '0;
      odata_q[1]   <= '0;
    end else begin
      twr_q        <= twr_d;
      trd_q        <= trd_d;
      req_full_q   <= ((twr_d - trd_d) == (TPW+1)'(TAG_DEPTH));
      owr_q        <= owr_d;
      ord_q        <= ord_d;
      line_valid_q <= (owr_d != ord_d);
      overflow_q   <= overflow_q | tag_push_drop | o_drop;
      beat_err_q   <= beat_err_q | end_err | tag_miss;
      if (o_push) begin
        otag_q[owr_q[0]]  <= tag_head;
        odata_q[owr_q[0]] <= line_asm;
      end
    end
  end

  assign bus.req_full   = req_full_q;
  assign bus.line_valid = line_valid_q;
  assign bus.line_tag   = otag_q[ord_q[0]];
  assign bus.line_data  = odata_q[ord_q[0]];
  assign bus.overflow   = overflow_q;
  assign bus.beat_err   = beat_err_q;

`ifdef MPMC9_RDCAP_STATS_EN
  logic [31:0] lines_done_q;
  logic [15:0] lines_dropped_q;
  logic        drop_evt;

  assign drop_evt = o_drop || end_err || tag_miss;

  always_ff @(posedge clk) begin
    if (rst) begin
      lines_done_q    <= '0;
      lines_dropped_q <= '0;
    end else begin
      if (o_pop)
        lines_done_q <= lines_done_q + 32'd1;
      if (drop_evt && lines_dropped_q != 16'hFFFF)
        lines_dropped_q <= lines_dropped_q + 16'd1;
    end
  end

  assign lines_done    = lines_done_q;
  assign lines_dropped = lines_dropped_q;
`endif
endmodule

// File: tb/tb_mpmc9_app_rd_data_capture.sv
// Directed bench for mpmc9_app_rd_data_capture: basic line, ordering, backpressure, errors, full FIFO, reset.
module tb_mpmc9_app_rd_data_capture;
  typedef logic [255:0] w_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  mpmc9_app_rd_data_capture_if #(.DW(128), .NBEATS(2), .TAGW(4)) bus ();

`ifdef MPMC9_RDCAP_STATS_EN
  logic [31:0] lines_done;
  logic [15:0] lines_dropped;
`endif

  mpmc9_app_rd_data_capture #(.DW(128), .NBEATS(2), .TAGW(4), .TAG_DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef MPMC9_RDCAP_STATS_EN
    ,
    .lines_done    (lines_done),
    .lines_dropped (lines_dropped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input w_t obs, input w_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic w_t ln(input logic [127:0] b0, input logic [127:0] b1);
    return {b1, b0};
  endfunction

  // Advance one clock; single-cycle pulses are dropped after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    bus.req_push          = 1'b0;
    bus.app_rd_data_valid = 1'b0;
    bus.app_rd_data_end   = 1'b0;
  endtask

  task automatic push(input logic [3:0] t);
    bus.req_push = 1'b1;
    bus.req_tag  = t;
    tick();
  endtask

  task automatic beat(input logic [127:0] d, input logic last);
    bus.app_rd_data       = d;
    bus.app_rd_data_valid = 1'b1;
    bus.app_rd_data_end   = last;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst                   = 1'b1;
    bus.req_push          = 1'b0;
    bus.req_tag           = '0;
    bus.app_rd_data       = '0;
    bus.app_rd_data_valid = 1'b0;
    bus.app_rd_data_end   = 1'b0;
    bus.line_ready        = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_line_valid", w_t'(bus.line_valid), w_t'(0));
    chk("rst_req_full",   w_t'(bus.req_full),   w_t'(0));
    chk("rst_overflow",   w_t'(bus.overflow),   w_t'(0));
    chk("rst_beat_err",   w_t'(bus.beat_err),   w_t'(0));
    chk("rst_line_tag",   w_t'(bus.line_tag),   w_t'(0));
    chk("rst_line_data",  w_t'(bus.line_data),  w_t'(0));
    $display("step reset: outputs checked");

    // Basic line
    push(4'd3);
    beat(128'h1, 1'b0);
    beat(128'h2, 1'b1);
    chk("basic_valid", w_t'(bus.line_valid), w_t'(1));
    chk("basic_tag",   w_t'(bus.line_tag),   w_t'(3));
    chk("basic_data",  w_t'(bus.line_data),  ln(128'h1, 128'h2));
    bus.line_ready = 1'b1;
    tick();
    chk("basic_pop", w_t'(bus.line_valid), w_t'(0));
    $display("step basic: tag=%0d data=%0h", bus.line_tag, bus.line_data);

    // Ordering, back-to-back with consumer ready
    push(4'd5);
    push(4'd9);
    push(4'd2);
    beat(128'h10, 1'b0);
    beat(128'h11, 1'b1);
    chk("ord0_tag",  w_t'(bus.line_tag),  w_t'(5));
    chk("ord0_data", w_t'(bus.line_data), ln(128'h10, 128'h11));
    beat(128'h20, 1'b0);
    chk("ord0_popped", w_t'(bus.line_valid), w_t'(0));
    beat(128'h21, 1'b1);
    chk("ord1_tag",  w_t'(bus.line_tag),  w_t'(9));
    chk("ord1_data", w_t'(bus.line_data), ln(128'h20, 128'h21));
    beat(128'h30, 1'b0);
    beat(128'h31, 1'b1);
    chk("ord2_tag",  w_t'(bus.line_tag),  w_t'(2));
    chk("ord2_data", w_t'(bus.line_data), ln(128'h30, 128'h31));
    tick();
    chk("ord_drained",  w_t'(bus.line_valid), w_t'(0));
    chk("ord_overflow", w_t'(bus.overflow),   w_t'(0));
    chk("ord_beat_err", w_t'(bus.beat_err),   w_t'(0));
    $display("step ordering: three lines returned");

    // Backpressure and output overflow
    bus.line_ready = 1'b0;
    push(4'd1);
    push(4'd4);
    push(4'd7);
    beat(128'h100, 1'b0);
    beat(128'h101, 1'b1);
    chk("bp_l1_tag", w_t'(bus.line_tag), w_t'(1));
    beat(128'h200, 1'b0);
    beat(128'h201, 1'b1);
    chk("bp_hold_tag",  w_t'(bus.line_tag),  w_t'(1));
    chk("bp_hold_data", w_t'(bus.line_data), ln(128'h100, 128'h101));
    chk("bp_no_ovf",    w_t'(bus.overflow),  w_t'(0));
    beat(128'h300, 1'b0);
    beat(128'h301, 1'b1);
    chk("bp_overflow", w_t'(bus.overflow),  w_t'(1));
    chk("bp_still_l1", w_t'(bus.line_tag),  w_t'(1));
    bus.line_ready = 1'b1;
    tick();
    chk("bp_l2_valid", w_t'(bus.line_valid), w_t'(1));
    chk("bp_l2_tag",   w_t'(bus.line_tag),   w_t'(4));
    chk("bp_l2_data",  w_t'(bus.line_data),  ln(128'h200, 128'h201));
    tick();
    chk("bp_empty", w_t'(bus.line_valid), w_t'(0));
    bus.line_ready = 1'b0;
`ifdef MPMC9_RDCAP_STATS_EN
    chk("bp_lines_done",    w_t'(lines_done),    w_t'(6));
    chk("bp_lines_dropped", w_t'(lines_dropped), w_t'(1));
`endif
    $display("step backpressure: overflow=%0b", bus.overflow);

    // End flagged on beat 0, then a good line
    do_reset();
    push(4'd6);
    beat(128'h400, 1'b1);
    chk("err_end_beat_err", w_t'(bus.beat_err),   w_t'(1));
    chk("err_end_no_line",  w_t'(bus.line_valid), w_t'(0));
    push(4'd8);
    beat(128'h500, 1'b0);
    beat(128'h501, 1'b1);
    chk("err_recover_valid", w_t'(bus.line_valid), w_t'(1));
    chk("err_recover_tag",   w_t'(bus.line_tag),   w_t'(8));
    chk("err_recover_data",  w_t'(bus.line_data),  ln(128'h500, 128'h501));
    $display("step early end: beat_err=%0b", bus.beat_err);

    // Line arriving with no outstanding tag
    do_reset();
    beat(128'h600, 1'b0);
    beat(128'h601, 1'b1);
    chk("notag_beat_err", w_t'(bus.beat_err),   w_t'(1));
    chk("notag_no_line",  w_t'(bus.line_valid), w_t'(0));
    chk("notag_overflow", w_t'(bus.overflow),   w_t'(0));
    $display("step missing tag: beat_err=%0b", bus.beat_err);

    // Tag FIFO full, dropped push, push accepted alongside a pop
    do_reset();
    for (int i = 0; i < 16; i++) begin
      push(4'(i));
      if (i == 14) chk("full_not_yet", w_t'(bus.req_full), w_t'(0));
    end
    chk("full_set", w_t'(bus.req_full), w_t'(1));
    push(4'hC);
    chk("full_push_ovf", w_t'(bus.overflow), w_t'(1));
    chk("full_kept",     w_t'(bus.req_full), w_t'(1));
    beat(128'h700, 1'b0);
    bus.req_push          = 1'b1;
    bus.req_tag           = 4'hA;
    bus.app_rd_data       = 128'h701;
    bus.app_rd_data_valid = 1'b1;
    bus.app_rd_data_end   = 1'b1;
    tick();
    chk("full_pp_valid", w_t'(bus.line_valid), w_t'(1));
    chk("full_pp_tag",   w_t'(bus.line_tag),   w_t'(0));
    chk("full_pp_data",  w_t'(bus.line_data),  ln(128'h700, 128'h701));
    chk("full_pp_full",  w_t'(bus.req_full),   w_t'(1));
    $display("step tag full: req_full=%0b overflow=%0b", bus.req_full, bus.overflow);
    bus.line_ready = 1'b1;
    for (int k = 1; k < 16; k++) begin
      beat(128'(k * 256), 1'b0);
      beat(128'(k * 256 + 1), 1'b1);
      chk("drain_tag", w_t'(bus.line_tag), w_t'(k));
    end
    beat(128'h1000, 1'b0);
    beat(128'h1001, 1'b1);
    chk("drain_last_tag",  w_t'(bus.line_tag),  w_t'(4'hA));
    chk("drain_last_data", w_t'(bus.line_data), ln(128'h1000, 128'h1001));
    chk("drain_not_full",  w_t'(bus.req_full),  w_t'(0));
    tick();
    bus.line_ready = 1'b0;
    $display("step drain: sixteen lines returned");

    // Reset in the middle of a line
    push(4'hB);
    beat(128'h800, 1'b0);
    do_reset();
    chk("mid_rst_valid",    w_t'(bus.line_valid), w_t'(0));
    chk("mid_rst_full",     w_t'(bus.req_full),   w_t'(0));
    chk("mid_rst_overflow", w_t'(bus.overflow),   w_t'(0));
    chk("mid_rst_beat_err", w_t'(bus.beat_err),   w_t'(0));
    chk("mid_rst_tag",      w_t'(bus.line_tag),   w_t'(0));
    chk("mid_rst_data",     w_t'(bus.line_data),  w_t'(0));
    push(4'hD);
    beat(128'h900, 1'b0);
    beat(128'h901, 1'b1);
    chk("post_rst_valid", w_t'(bus.line_valid), w_t'(1));
    chk("post_rst_tag",   w_t'(bus.line_tag),   w_t'(4'hD));
    chk("post_rst_data",  w_t'(bus.line_data),  ln(128'h900, 128'h901));
    chk("post_rst_err",   w_t'(bus.beat_err),   w_t'(0));
    bus.line_ready = 1'b1;
    tick();
    chk("post_rst_pop", w_t'(bus.line_valid), w_t'(0));
    bus.line_ready = 1'b0;
`ifdef MPMC9_RDCAP_STATS_EN
    chk("post_rst_lines_done",    w_t'(lines_done),    w_t'(1));
    chk("post_rst_lines_dropped", w_t'(lines_dropped), w_t'(0));
`endif
    $display("step mid-line reset: tag=%0h", bus.line_tag);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
